motor_pwm_drv: RTL

MOTOR_PWM_DRV -- requirements
Module: motor_pwm_drv

---
 rtl/motor_pwm_drv.sv | 126 ++++++++++++
 1 files changed

// File: rtl/motor_pwm_drv.sv
// Dual-channel motor PWM driver: per-period command sampling, sign/magnitude
// split, one dead period on every direction reversal, go gating.

module motor_pwm_ch #(
    parameter int PERIOD_BITS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   smp,
    input  logic [PERIOD_BITS-1:0] cnt,
    input  logic [10:0]            cmd,
    output logic                   pwm,
    output logic                   dir
);
    localparam int CW = (PERIOD_BITS > 10) ? PERIOD_BITS : 10;

    logic [10:0] neg;
    logic [9:0]  mag;
    logic [9:0]  duty_q, duty_d;
    logic        dir_q, dir_d;
    logic        pwm_q, pwm_d;

    always_comb begin
        neg = ~cmd + 11'd1;
        if (cmd == 11'h400)
            mag = 10'h3ff;
        else if (cmd[10])
            mag = neg[9:0];
        else
            mag = cmd[9:0];

        duty_d = duty_q;
        dir_d  = dir_q;
        if (!go) begin
            duty_d = '0;
        end else if (smp) begin
            if (mag == '0) begin
                duty_d = '0;
            end else if (cmd[10] == dir_q) begin
                duty_d = mag;
            end else begin
                // reversal: idle for one full period before driving the new way
                duty_d = '0;
                dir_d  = cmd[10];
            end
        end

        pwm_d = go && (CW'(cnt) < CW'(duty_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
            dir_q  <= 1'b0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            dir_q  <= dir_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm = pwm_q;
    assign dir = dir_q;
endmodule

module motor_pwm_drv #(
    parameter int PERIOD_BITS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic signed [10:0] lft,
    input  logic signed [10:0] rht,
    output logic               PWM_lft,
    output logic               PWM_rht,
    output logic               dir_lft,
    output logic               dir_rht,
    output logic               prd_strt
);
    localparam logic [PERIOD_BITS-1:0] CNT_MAX = '1;

    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic                   prd_strt_q, prd_strt_d;
    logic                   smp;
    logic [1:0][10:0]       cmd;
    logic [1:0]             pwm, dir;

    always_comb begin
        smp        = (cnt_q == CNT_MAX);
        cnt_d      = cnt_q + PERIOD_BITS'(1);
        prd_strt_d = smp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            prd_strt_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prd_strt_q <= prd_strt_d;
        end
    end

    assign cmd = {rht, lft};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        motor_pwm_ch #(.PERIOD_BITS(PERIOD_BITS)) u_ch (
            .clk (clk),
            .rst (rst),
            .go  (go),
            .smp (smp),
            .cnt (cnt_q),
            .cmd (cmd[i]),
            .pwm (pwm[i]),
            .dir (dir[i])
        );
    end

    assign PWM_lft  = pwm[0];
    assign PWM_rht  = pwm[1];
    assign dir_lft  = dir[0];
    assign dir_rht  = dir[1];
    assign prd_strt = prd_strt_q;
endmodule
